instr_stream_loader: RTL and testbench
======================================

Name: instr_stream_loader

Overview:
- Upstream front end of the CPU. It takes the serial 8-bit instruction byte stream (one byte per clock) and frames it with the start marker 8'hFE and the end marker 8'hFF.
- It packs bytes big-endian into 32-bit instruction words and writes them into the instruction memory.
- When loading completes, it issues a one-cycle start pulse to the CPU core.

Parameters:
- DEPTH, 64, instruction-memory depth in 32-bit words.
- AW, 6, instruction-memory address width; must satisfy 2^AW >= DEPTH.
- START_BYTE, 8'hFE, stream start marker.
- END_BYTE, 8'hFF, stream end marker.

Ports:
- clk_i  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- instr_i  input  8  serial stream byte, sampled on every rising edge.
- imem_we  output  1  instruction-memory write strobe.
- imem_addr  output  AW  word address for the write.
- imem_wdata  output  32  assembled instruction word.
- busy  output  1  high while in LOAD.
- load_done  output  1  level; high in DONE.
- cpu_start  output  1  single-cycle pulse on DONE entry.
- word_cnt  output  AW+1  number of words written in the current load.
- overflow  output  1  sticky; set when the memory filled before END_BYTE arrived.

Behaviour:
- Reset (asynchronous): state=IDLE; byte index=0; shift register=0; all outputs 0.
- IDLE:
  - Every byte is ignored except START_BYTE, which enters LOAD.
  - On entry to LOAD: byte index=0, word_cnt=0, overflow=0.
  - The marker byte itself is not stored.
- LOAD, byte index 0:
  - END_BYTE: enter DONE.
  - START_BYTE: restart the load (word_cnt=0, address 0, no write).
  - Any other byte, including 8'h00: becomes bits [31:24] of the word; index=1.
  - Consequence: words whose MSB is 8'hFE or 8'hFF cannot be loaded. This is an accepted ISA restriction.
- LOAD, byte index 1..3:
  - Every byte is data, including FE and FF.
  - Index 1 fills bits [23:16], index 2 fills [15:8], index 3 fills [7:0].
- Word write:
  - In the cycle after the 4th byte is sampled: imem_we=1 for exactly one cycle, imem_addr=word_cnt (pre-increment), imem_wdata=assembled word.
  - word_cnt increments on the same edge that asserts imem_we; index wraps to 0.
  - Back-to-back words therefore produce writes every 4th cycle.
- Overflow:
  - When word_cnt reaches DEPTH after a write: set overflow=1 and enter DONE without waiting for END_BYTE.
  - Further bytes are ignored.
- Partial word:
  - If the load ends with index != 0, the partial word is not possible, because END_BYTE at index 1..3 is data.
  - The only way to leave LOAD is END_BYTE at index 0, overflow, or reset.
- DONE:
  - load_done=1 and busy=0.
  - cpu_start=1 for the single cycle following DONE entry.
  - word_cnt and overflow are held.
  - All bytes are ignored, including START_BYTE. A reload requires reset.
- imem_we is never asserted outside LOAD or in the DONE-entry cycle, except for the final write of an overflowing load, which is issued before the DONE transition.
- Reset asserted mid-load: all state is cleared immediately and no write strobe is issued. Writes already committed to the memory are not undone.
- busy is a registered output: 1 from the cycle after START_BYTE is sampled until the cycle DONE is entered.

Test Plan:
- Basic load:
  - Stimulus: reset, then 00, 00, FE, 12, 34, 56, 78, 9A, BC, DE, F0, FF.
  - Required: two writes, addr0=0x12345678 and addr1=0x9ABCDEF0, 4 cycles apart; word_cnt=2; load_done=1; one cpu_start pulse; overflow=0.
- Embedded markers and zeros:
  - Stimulus: FE, 01, FF, FE, 00, FF.
  - Required: one write, addr0=0x01FFFE00; DONE entered on the final FF.
- Restart:
  - Stimulus: FE, AA, BB, CC, DD, FE, 11, 22, 33, 44, FF.
  - Required: writes addr0=0xAABBCCDD, then addr0=0x11223344; final word_cnt=1.
- Overflow (DEPTH=64):
  - Stimulus: FE followed by 65 words of 01, 02, 03, 04 and no FF.
  - Required: exactly 64 writes to addresses 0..63; overflow=1; load_done=1; the 65th word produces no write.
- Reset mid-word:
  - Stimulus: FE, 12, 34, then assert reset asynchronously between edges.
  - Required: all outputs drop to 0 immediately; no imem_we. After release, bytes 56, 78, FF are ignored because the block is in IDLE.
- DONE lock:
  - Stimulus: after a completed load, send FE, 11, 22, 33, 44.
  - Required: no imem_we; load_done stays 1; cpu_start does not re-pulse.

Source files
------------

// File: rtl/instr_stream_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_stream_loader_if
// Purpose  : Byte-stream input, instruction-memory write port and load status.
// Revision : 1.0  initial release
// ============================================================================
interface instr_stream_loader_if #(
  parameter int AW = 6
);
  logic [7:0]    instr_i;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          busy;
  logic          load_done;
  logic          cpu_start;
  logic [AW:0]   word_cnt;
  logic          overflow;

  modport master (
    input  instr_i,
    output imem_we, imem_addr, imem_wdata,
    output busy, load_done, cpu_start, word_cnt, overflow
  );

  modport slave (
    output instr_i,
    input  imem_we, imem_addr, imem_wdata,
    input  busy, load_done, cpu_start, word_cnt, overflow
  );
endinterface
`default_nettype wire

// File: rtl/instr_stream_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_stream_loader
// Purpose  : Frames a serial byte stream into big-endian 32-bit words, writes
//            them to instruction memory and pulses cpu_start when loading ends.
// Revision : 1.0  initial release
// ============================================================================
module instr_stream_loader #(
  parameter int         DEPTH      = 64,
  parameter int         AW         = 6,
  parameter logic [7:0] START_BYTE = 8'hFE,
  parameter logic [7:0] END_BYTE   = 8'hFF
) (
  input  wire                          clk_i,
  input  wire                          reset,
  instr_stream_loader_if.master        bus
);

  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state, w_state;
  logic [1:0]    r_idx, w_idx;
  logic [23:0]   r_shift, w_shift;
  logic          r_we, w_we;
  logic [AW-1:0] r_addr, w_addr;
  logic [31:0]   r_wdata, w_wdata;
  logic [AW:0]   r_cnt, w_cnt;
  logic          r_ovf, w_ovf;
  logic          r_start, w_start;
  logic [AW:0]   w_cnt_inc;

  assign w_cnt_inc = r_cnt + 1'b1;

  always_comb begin
    w_state = r_state;
    w_idx   = r_idx;
    w_shift = r_shift;
    w_we    = 1'b0;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_cnt   = r_cnt;
    w_ovf   = r_ovf;
    w_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.instr_i == START_BYTE) begin
          w_state = S_LOAD;
          w_idx   = 2'd0;
          w_cnt   = '0;
          w_ovf   = 1'b0;
        end
      end
      S_LOAD: begin
        // Markers are only recognised at a word boundary; mid-word they are data.
        if (r_idx == 2'd0 && bus.instr_i == END_BYTE) begin
          w_state = S_DONE;
          w_start = 1'b1;
        end else if (r_idx == 2'd0 && bus.instr_i == START_BYTE) begin
          w_cnt = '0;
        end else begin
          w_shift = {r_shift[15:0], bus.instr_i};
          w_idx   = r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            w_we    = 1'b1;
            w_addr  = r_cnt[AW-1:0];
            w_wdata = {r_shift, bus.instr_i};
            w_cnt   = w_cnt_inc;
            if (w_cnt_inc == C_DEPTH) begin
              w_ovf   = 1'b1;
              w_state = S_DONE;
              w_start = 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        w_state = S_DONE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= 2'd0;
      r_shift <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_start <= 1'b0;
    end else begin
      r_state <= w_state;
      r_idx   <= w_idx;
      r_shift <= w_shift;
      r_we    <= w_we;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_cnt   <= w_cnt;
      r_ovf   <= w_ovf;
      r_start <= w_start;
    end
  end

  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign bus.busy       = (r_state == S_LOAD);
  assign bus.load_done  = (r_state == S_DONE);
  assign bus.cpu_start  = r_start;
  assign bus.word_cnt   = r_cnt;
  assign bus.overflow   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_instr_stream_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_stream_loader
// Purpose  : Directed and randomized stream bench for instr_stream_loader.
// Revision : 1.0  initial release
// ============================================================================
module tb_instr_stream_loader;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  instr_stream_loader_if #(.AW(AW)) bus ();

  instr_stream_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_i (clk),
    .reset (rst),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // Reference: stream framing rules applied one byte at a time.
  int          m_mode;      // 0 idle, 1 loading, 2 finished
  int          m_bytes;     // bytes collected for the current word
  logic [31:0] m_word;
  int          m_cnt;
  logic        m_ovf;
  logic        e_we, e_start;
  int          e_addr;
  logic [31:0] e_data;

  task automatic model_reset();
    m_mode = 0; m_bytes = 0; m_word = 0; m_cnt = 0; m_ovf = 0;
    e_we = 0; e_start = 0; e_addr = 0; e_data = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    e_we = 0; e_start = 0;
    if (m_mode == 0) begin
      if (b == 8'hFE) begin m_mode = 1; m_bytes = 0; m_cnt = 0; m_ovf = 0; end
    end else if (m_mode == 1) begin
      if (m_bytes == 0 && b == 8'hFF) begin
        m_mode = 2; e_start = 1;
      end else if (m_bytes == 0 && b == 8'hFE) begin
        m_cnt = 0;
      end else begin
        m_word = m_word * 256 + 32'(b);
        m_bytes++;
        if (m_bytes == 4) begin
          e_we = 1; e_addr = m_cnt; e_data = m_word;
          m_cnt++; m_bytes = 0;
          if (m_cnt == DEPTH) begin m_ovf = 1; m_mode = 2; e_start = 1; end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".we"},    64'(bus.imem_we),   64'(e_we));
    chk({tag, ".busy"},  64'(bus.busy),      64'(m_mode == 1));
    chk({tag, ".done"},  64'(bus.load_done), 64'(m_mode == 2));
    chk({tag, ".start"}, 64'(bus.cpu_start), 64'(e_start));
    chk({tag, ".cnt"},   64'(bus.word_cnt),  64'(m_cnt));
    chk({tag, ".ovf"},   64'(bus.overflow),  64'(m_ovf));
    if (e_we) begin
      chk({tag, ".addr"}, 64'(bus.imem_addr),  64'(e_addr));
      chk({tag, ".data"}, 64'(bus.imem_wdata), 64'(e_data));
    end
  endtask

  task automatic send(input string tag, input logic [7:0] b);
    bus.instr_i = b;
    @(posedge clk); #1;
    model_byte(b);
    check_outputs(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("rst.addr",  64'(bus.imem_addr),  64'd0);
    chk("rst.wdata", 64'(bus.imem_wdata), 64'd0);
    check_outputs("rst");
  endtask

  initial begin
    logic [7:0] basic [12];
    logic [7:0] embed [6];
    logic [7:0] rstrt [11];
    logic [7:0] lockb [5];
    basic = '{8'h00, 8'h00, 8'hFE, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'hFF};
    embed = '{8'hFE, 8'h01, 8'hFF, 8'hFE, 8'h00, 8'hFF};
    rstrt = '{8'hFE, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hFE, 8'h11, 8'h22, 8'h33, 8'h44, 8'hFF};
    lockb = '{8'hFE, 8'h11, 8'h22, 8'h33, 8'h44};
    bus.instr_i = 8'h00;
    model_reset();
    do_reset();

    foreach (basic[i]) send("basic", basic[i]);
    chk("basic.final_cnt", 64'(bus.word_cnt), 64'd2);
    foreach (lockb[i]) send("lock", lockb[i]);
    send("lock", 8'hFF);

    do_reset();
    foreach (embed[i]) send("embed", embed[i]);
    chk("embed.done", 64'(bus.load_done), 64'd1);

    do_reset();
    foreach (rstrt[i]) send("restart", rstrt[i]);
    chk("restart.final_cnt", 64'(bus.word_cnt), 64'd1);

    do_reset();
    send("ovf", 8'hFE);
    for (int w = 0; w < 65; w++) begin
      send("ovf", 8'h01); send("ovf", 8'h02); send("ovf", 8'h03); send("ovf", 8'h04);
    end
    chk("ovf.flag", 64'(bus.overflow), 64'd1);
    chk("ovf.cnt",  64'(bus.word_cnt), 64'(DEPTH));

    // Asynchronous reset in the middle of a clock period.
    do_reset();
    send("midrst", 8'hFE); send("midrst", 8'h12); send("midrst", 8'h34);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("midrst.addr",  64'(bus.imem_addr),  64'd0);
    chk("midrst.wdata", 64'(bus.imem_wdata), 64'd0);
    check_outputs("midrst.async");
    @(posedge clk); #1;
    check_outputs("midrst.held");
    rst = 1'b0;
    send("midrst", 8'h56); send("midrst", 8'h78); send("midrst", 8'hFF);

    for (int r = 0; r < 8; r++) begin
      int nw;
      do_reset();
      for (int g = 0; g < int'($urandom_range(0, 3)); g++)
        send("rand.idle", 8'($urandom_range(0, 253)));
      send("rand", 8'hFE);
      nw = int'($urandom_range(1, 6));
      for (int w = 0; w < nw; w++) begin
        if ($urandom_range(0, 9) == 0) send("rand.re", 8'hFE);
        send("rand", 8'($urandom_range(0, 253)));
        for (int k = 0; k < 3; k++) send("rand", 8'($urandom));
      end
      send("rand.end", 8'hFF);
      for (int k = 0; k < 3; k++) send("rand.post", 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
